// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences one TLB maintenance operation (TLBSRCH, TLBRD, TLBWR,
// TLBFILL, INVTLB) through IDLE -> EXEC -> DONE. It drives the TLB search,
// read, write and invalidate ports during EXEC and returns CSR results in DONE.
// Optional macro TLB_FILL_RANDOM_EN: when defined, the TLBFILL index comes from
// a free-running counter instead of the round-robin pointer.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [4:0]    inv_op,
    input  logic [9:0]    inv_asid,
    input  logic [18:0]   inv_vppn,
    input  logic [IW-1:0] csr_index,
    input  logic          csr_ne,
    input  logic [5:0]    csr_ps,
    input  logic [18:0]   csr_vppn,
    input  logic [9:0]    csr_asid,
    input  logic [5:0]    csr_ecode,
    input  logic [26:0]   csr_elo0,
    input  logic [26:0]   csr_elo1,
    // search port
    output logic [18:0]   s_vppn,
    output logic          s_va_bit12,
    output logic [9:0]    s_asid,
    input  logic          s_found,
    input  logic [IW-1:0] s_index,
    // write port
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic          w_e,
    output logic [18:0]   w_vppn,
    output logic [5:0]    w_ps,
    output logic [9:0]    w_asid,
    output logic          w_g,
    output logic [19:0]   w_ppn0,
    output logic [1:0]    w_plv0,
    output logic [1:0]    w_mat0,
    output logic          w_d0,
    output logic          w_v0,
    output logic [19:0]   w_ppn1,
    output logic [1:0]    w_plv1,
    output logic [1:0]    w_mat1,
    output logic          w_d1,
    output logic          w_v1,
    // read port
    output logic [IW-1:0] r_index,
    input  logic          r_e,
    input  logic [18:0]   r_vppn,
    input  logic [5:0]    r_ps,
    input  logic [9:0]    r_asid,
    input  logic          r_g,
    input  logic [19:0]   r_ppn0,
    input  logic [1:0]    r_plv0,
    input  logic [1:0]    r_mat0,
    input  logic          r_d0,
    input  logic          r_v0,
    input  logic [19:0]   r_ppn1,
    input  logic [1:0]    r_plv1,
    input  logic [1:0]    r_mat1,
    input  logic          r_d1,
    input  logic          r_v1,
    // invalidate port
    output logic          invtlb_valid,
    output logic [4:0]    invtlb_op,
    // completion and CSR results
    output logic          done,
    output logic          res_we,
    output logic [IW-1:0] res_index,
    output logic          res_ne,
    output logic [5:0]    res_ps,
    output logic [18:0]   res_vppn,
    output logic [9:0]    res_asid,
    output logic [26:0]   res_elo0,
    output logic [26:0]   res_elo1,
    output logic          res_err
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    state_t        state_q, state_d;
    logic [2:0]    op_q;
    logic [4:0]    inv_op_q;
    logic [9:0]    inv_asid_q;
    logic [18:0]   inv_vppn_q;
    logic [IW-1:0] index_q;
    logic          ne_q;
    logic [5:0]    ps_q;
    logic [18:0]   vppn_q;
    logic [9:0]    asid_q;
    logic [5:0]    ecode_q;
    logic [26:0]   elo0_q, elo1_q;
    logic [IW-1:0] fill_q, fill_d;

    logic [IW-1:0] res_index_q, res_index_d;
    logic          res_ne_q, res_ne_d;
    logic [5:0]    res_ps_q, res_ps_d;
    logic [18:0]   res_vppn_q, res_vppn_d;
    logic [9:0]    res_asid_q, res_asid_d;
    logic [26:0]   res_elo0_q, res_elo0_d;
    logic [26:0]   res_elo1_q, res_elo1_d;

    logic accept;
    logic in_exec;
    logic op_legal;

    function automatic logic [IW-1:0] next_fill(input logic [IW-1:0] cur);
        return (cur == IW'(TLBNUM - 1)) ? '0 : cur + 1'b1;
    endfunction

    assign accept   = (state_q == S_IDLE) && req_valid;
    assign in_exec  = (state_q == S_EXEC);
    assign op_legal = (op_q <= OP_INV);

    assign req_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_DONE);
    assign res_we    = done && ((op_q == OP_SRCH) || (op_q == OP_RD));
    assign res_err   = done && !op_legal;

    assign res_index = res_index_q;
    assign res_ne    = res_ne_q;
    assign res_ps    = res_ps_q;
    assign res_vppn  = res_vppn_q;
    assign res_asid  = res_asid_q;
    assign res_elo0  = res_elo0_q;
    assign res_elo1  = res_elo1_q;

    // State register; async reset aborts any in-flight op without a done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: each state lasts one cycle, only IDLE accepts a request
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Capture op and operands on accept so EXEC sees a stable snapshot
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q       <= req_op;
            inv_op_q   <= inv_op;
            inv_asid_q <= inv_asid;
            inv_vppn_q <= inv_vppn;
            index_q    <= csr_index;
            ne_q       <= csr_ne;
            ps_q       <= csr_ps;
            vppn_q     <= csr_vppn;
            asid_q     <= csr_asid;
            ecode_q    <= csr_ecode;
            elo0_q     <= csr_elo0;
            elo1_q     <= csr_elo1;
        end
    end

    // TLB port drive: everything idles at zero outside EXEC or for illegal ops
    always_comb begin
        s_vppn       = '0;
        s_va_bit12   = 1'b0;
        s_asid       = '0;
        we           = 1'b0;
        w_index      = '0;
        w_e          = 1'b0;
        w_vppn       = '0;
        w_ps         = '0;
        w_asid       = '0;
        w_g          = 1'b0;
        {w_ppn0, w_plv0, w_mat0, w_d0, w_v0} = '0;
        {w_ppn1, w_plv1, w_mat1, w_d1, w_v1} = '0;
        r_index      = '0;
        invtlb_valid = 1'b0;
        invtlb_op    = '0;
        if (in_exec) begin
            case (op_q)
                OP_SRCH: begin
                    s_vppn = vppn_q;
                    s_asid = asid_q;
                end
                OP_RD: r_index = index_q;
                OP_WR, OP_FILL: begin
                    we      = 1'b1;
                    w_index = (op_q == OP_FILL) ? fill_q : index_q;
                    // ecode 0x3F marks TLB refill, where the entry is always valid
                    w_e     = (ecode_q == 6'h3F) ? 1'b1 : ~ne_q;
                    w_vppn  = vppn_q;
                    w_ps    = ps_q;
                    w_asid  = asid_q;
                    w_g     = elo0_q[6] & elo1_q[6];
                    w_ppn0  = elo0_q[26:7];
                    w_mat0  = elo0_q[5:4];
                    w_plv0  = elo0_q[3:2];
                    w_d0    = elo0_q[1];
                    w_v0    = elo0_q[0];
                    w_ppn1  = elo1_q[26:7];
                    w_mat1  = elo1_q[5:4];
                    w_plv1  = elo1_q[3:2];
                    w_d1    = elo1_q[1];
                    w_v1    = elo1_q[0];
                end
                OP_INV: begin
                    invtlb_valid = 1'b1;
                    invtlb_op    = inv_op_q;
                    s_vppn       = inv_vppn_q;
                    s_asid       = inv_asid_q;
                end
                default: ;
            endcase
        end
    end

    // Result next-state: only SRCH and RD update the CSR result fields
    always_comb begin
        res_index_d = res_index_q;
        res_ne_d    = res_ne_q;
        res_ps_d    = res_ps_q;
        res_vppn_d  = res_vppn_q;
        res_asid_d  = res_asid_q;
        res_elo0_d  = res_elo0_q;
        res_elo1_d  = res_elo1_q;
        if (in_exec && op_q == OP_SRCH) begin
            res_ne_d    = ~s_found;
            res_index_d = s_found ? s_index : index_q;
        end else if (in_exec && op_q == OP_RD) begin
            res_index_d = index_q;
            res_ne_d    = ~r_e;
            if (r_e) begin
                res_ps_d   = r_ps;
                res_vppn_d = r_vppn;
                res_asid_d = r_asid;
                res_elo0_d = {r_ppn0, r_g, r_mat0, r_plv0, r_d0, r_v0};
                res_elo1_d = {r_ppn1, r_g, r_mat1, r_plv1, r_d1, r_v1};
            end else begin
                res_ps_d   = '0;
                res_vppn_d = '0;
                res_asid_d = '0;
                res_elo0_d = '0;
                res_elo1_d = '0;
            end
        end
    end

    // Result registers, captured at the end of EXEC and held until the next op
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_index_q <= '0;
            res_ne_q    <= 1'b0;
            res_ps_q    <= '0;
            res_vppn_q  <= '0;
            res_asid_q  <= '0;
            res_elo0_q  <= '0;
            res_elo1_q  <= '0;
        end else begin
            res_index_q <= res_index_d;
            res_ne_q    <= res_ne_d;
            res_ps_q    <= res_ps_d;
            res_vppn_q  <= res_vppn_d;
            res_asid_q  <= res_asid_d;
            res_elo0_q  <= res_elo0_d;
            res_elo1_q  <= res_elo1_d;
        end
    end

    // Fill index source: free-running counter or round-robin pointer
    always_comb begin
`ifdef TLB_FILL_RANDOM_EN
        fill_d = next_fill(fill_q);
`else
        fill_d = fill_q;
        if (in_exec && op_q == OP_FILL) fill_d = next_fill(fill_q);
`endif
    end

    // Fill index register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fill_q <= '0;
        else       fill_q <= fill_d;
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed and randomized transactions against a transaction-level
// reference model of the TLB operation controller.
module tb_tlb_op_ctrl;
    localparam int TLBNUM = 16;
    localparam int IW = $clog2(TLBNUM);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0, req_ready;
    logic [2:0] req_op = '0;
    logic [4:0] inv_op = '0;
    logic [9:0] inv_asid = '0;
    logic [18:0] inv_vppn = '0;
    logic [IW-1:0] csr_index = '0;
    logic csr_ne = 1'b0;
    logic [5:0] csr_ps = '0;
    logic [18:0] csr_vppn = '0;
    logic [9:0] csr_asid = '0;
    logic [5:0] csr_ecode = '0;
    logic [26:0] csr_elo0 = '0, csr_elo1 = '0;
    logic [18:0] s_vppn; logic s_va_bit12; logic [9:0] s_asid;
    logic s_found = 1'b0; logic [IW-1:0] s_index = '0;
    logic we, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [IW-1:0] w_index; logic [18:0] w_vppn; logic [5:0] w_ps; logic [9:0] w_asid;
    logic [19:0] w_ppn0, w_ppn1; logic [1:0] w_plv0, w_mat0, w_plv1, w_mat1;
    logic [IW-1:0] r_index;
    logic r_e = 1'b0, r_g = 1'b0, r_d0 = 1'b0, r_v0 = 1'b0, r_d1 = 1'b0, r_v1 = 1'b0;
    logic [18:0] r_vppn = '0; logic [5:0] r_ps = '0; logic [9:0] r_asid = '0;
    logic [19:0] r_ppn0 = '0, r_ppn1 = '0;
    logic [1:0] r_plv0 = '0, r_mat0 = '0, r_plv1 = '0, r_mat1 = '0;
    logic invtlb_valid; logic [4:0] invtlb_op;
    logic done, res_we, res_ne, res_err;
    logic [IW-1:0] res_index; logic [5:0] res_ps; logic [18:0] res_vppn;
    logic [9:0] res_asid; logic [26:0] res_elo0, res_elo1;

    int n_tests = 0;
    int n_fail = 0;

    // reference model state
    int          m_fill = 0;
    logic [IW-1:0] m_index = '0;
    logic        m_ne = 1'b0;
    logic [5:0]  m_ps = '0;
    logic [18:0] m_vppn = '0;
    logic [9:0]  m_asid = '0;
    logic [26:0] m_elo0 = '0, m_elo1 = '0;

    tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
        .csr_index(csr_index), .csr_ne(csr_ne), .csr_ps(csr_ps), .csr_vppn(csr_vppn),
        .csr_asid(csr_asid), .csr_ecode(csr_ecode), .csr_elo0(csr_elo0), .csr_elo1(csr_elo1),
        .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
        .s_found(s_found), .s_index(s_index),
        .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
        .w_asid(w_asid), .w_g(w_g),
        .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
        .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid),
        .r_g(r_g), .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0),
        .r_v0(r_v0), .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1),
        .r_v1(r_v1),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
        .done(done), .res_we(res_we), .res_index(res_index), .res_ne(res_ne),
        .res_ps(res_ps), .res_vppn(res_vppn), .res_asid(res_asid),
        .res_elo0(res_elo0), .res_elo1(res_elo1), .res_err(res_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fill = 0; m_index = '0; m_ne = 1'b0; m_ps = '0; m_vppn = '0;
        m_asid = '0; m_elo0 = '0; m_elo1 = '0;
    endtask

    task automatic check_results(input string pfx);
        chk({pfx, "_res_index"}, 64'(res_index), 64'(m_index));
        chk({pfx, "_res_ne"},    64'(res_ne),    64'(m_ne));
        chk({pfx, "_res_ps"},    64'(res_ps),    64'(m_ps));
        chk({pfx, "_res_vppn"},  64'(res_vppn),  64'(m_vppn));
        chk({pfx, "_res_asid"},  64'(res_asid),  64'(m_asid));
        chk({pfx, "_res_elo0"},  64'(res_elo0),  64'(m_elo0));
        chk({pfx, "_res_elo1"},  64'(res_elo1),  64'(m_elo1));
    endtask

    // One operation using the current operand/TLB-response variables.
    task automatic txn(input logic [2:0] op, input bit rst_mid);
        logic [IW-1:0] idx;  logic ne; logic [5:0] ps, ecode; logic [18:0] vppn, ivppn;
        logic [9:0] asid, iasid; logic [26:0] elo0, elo1; logic [4:0] iop;
        logic legal, wr;
        idx = csr_index; ne = csr_ne; ps = csr_ps; vppn = csr_vppn; asid = csr_asid;
        ecode = csr_ecode; elo0 = csr_elo0; elo1 = csr_elo1;
        iop = inv_op; iasid = inv_asid; ivppn = inv_vppn;
        legal = (op <= 3'd4);
        wr = (op == 3'd2) || (op == 3'd3);

        @(negedge clk);
        chk("idle_ready", 64'(req_ready), 64'd1);
        chk("idle_done", 64'(done), 64'd0);
        req_valid = 1'b1; req_op = op;
        @(posedge clk);
        @(negedge clk);
        // operands change and a new request is offered while busy
        csr_index = IW'($urandom); csr_ne = 1'($urandom); csr_ps = 6'($urandom);
        csr_vppn = 19'($urandom); csr_asid = 10'($urandom); csr_ecode = 6'($urandom);
        csr_elo0 = 27'($urandom); csr_elo1 = 27'($urandom);
        inv_op = 5'($urandom); inv_asid = 10'($urandom); inv_vppn = 19'($urandom);
        req_op = 3'($urandom);
        #1;
        chk("exec_ready", 64'(req_ready), 64'd0);
        chk("exec_done", 64'(done), 64'd0);
        chk("exec_we", 64'(we), 64'(wr));
        chk("exec_inv_valid", 64'(invtlb_valid), 64'(op == 3'd4));
        if (wr) begin
            chk("w_index", 64'(w_index), (op == 3'd3) ? 64'(m_fill) : 64'(idx));
            chk("w_e", 64'(w_e), (ecode == 6'h3F) ? 64'd1 : 64'(!ne));
            chk("w_g", 64'(w_g), 64'(elo0[6] & elo1[6]));
            chk("w_vppn", 64'(w_vppn), 64'(vppn));
            chk("w_ps", 64'(w_ps), 64'(ps));
            chk("w_asid", 64'(w_asid), 64'(asid));
            chk("w_lo0", 64'({w_ppn0, w_mat0, w_plv0, w_d0, w_v0}),
                64'({elo0[26:7], elo0[5:0]}));
            chk("w_lo1", 64'({w_ppn1, w_mat1, w_plv1, w_d1, w_v1}),
                64'({elo1[26:7], elo1[5:0]}));
        end
        if (op == 3'd0) begin
            chk("s_vppn", 64'(s_vppn), 64'(vppn));
            chk("s_asid", 64'(s_asid), 64'(asid));
            chk("s_bit12", 64'(s_va_bit12), 64'd0);
        end
        if (op == 3'd1) chk("r_index", 64'(r_index), 64'(idx));
        if (op == 3'd4) begin
            chk("invtlb_op", 64'(invtlb_op), 64'(iop));
            chk("inv_s_vppn", 64'(s_vppn), 64'(ivppn));
            chk("inv_s_asid", 64'(s_asid), 64'(iasid));
        end
        if (rst_mid) begin
            reset = 1'b1;
            #1;
            chk("rst_inv_valid", 64'(invtlb_valid), 64'd0);
            chk("rst_we", 64'(we), 64'd0);
            chk("rst_ready", 64'(req_ready), 64'd1);
            chk("rst_done", 64'(done), 64'd0);
            model_reset();
            req_valid = 1'b0;
            @(negedge clk);
            reset = 1'b0;
            chk("post_rst_done", 64'(done), 64'd0);
            check_results("post_rst");
            return;
        end
        // reference model update
        if (op == 3'd0) begin
            m_ne = !s_found;
            m_index = s_found ? s_index : idx;
        end else if (op == 3'd1) begin
            m_index = idx;
            m_ne = !r_e;
            if (r_e) begin
                m_ps = r_ps; m_vppn = r_vppn; m_asid = r_asid;
                m_elo0 = {r_ppn0, r_g, r_mat0, r_plv0, r_d0, r_v0};
                m_elo1 = {r_ppn1, r_g, r_mat1, r_plv1, r_d1, r_v1};
            end else begin
                m_ps = '0; m_vppn = '0; m_asid = '0; m_elo0 = '0; m_elo1 = '0;
            end
        end else if (op == 3'd3) begin
            m_fill = (m_fill + 1) % TLBNUM;
        end
        @(posedge clk);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_res_we", 64'(res_we), 64'(op <= 3'd1));
        chk("done_res_err", 64'(res_err), 64'(!legal));
        chk("done_we", 64'(we), 64'd0);
        chk("done_inv_valid", 64'(invtlb_valid), 64'd0);
        chk("done_ready", 64'(req_ready), 64'd0);
        check_results("done");
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("after_done", 64'(done), 64'd0);
        chk("after_ready", 64'(req_ready), 64'd1);
        chk("after_res_index", 64'(res_index), 64'(m_index));
    endtask

    initial begin
        #2;
        chk("reset_ready", 64'(req_ready), 64'd1);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_we", 64'(we), 64'd0);
        chk("reset_inv_valid", 64'(invtlb_valid), 64'd0);
        chk("reset_res_we", 64'(res_we), 64'd0);
        chk("reset_res_err", 64'(res_err), 64'd0);
        check_results("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 17 FILLs from reset: index walks 0..15 then wraps to 0
        for (int i = 0; i < 17; i++) begin
            csr_elo0 = 27'($urandom); csr_elo1 = 27'($urandom);
            csr_ecode = 6'h3F;
            chk("fill_seq", 64'(m_fill), 64'(i % TLBNUM));
            txn(3'd3, 1'b0);
        end

        // SRCH hit at index 5
        csr_vppn = 19'h12345; csr_asid = 10'h0AB; csr_index = 4'd9;
        s_found = 1'b1; s_index = 4'd5;
        txn(3'd0, 1'b0);
        chk("srch_hit_idx", 64'(m_index), 64'd5);
        // SRCH miss keeps the TLBIDX index
        csr_index = 4'd3; s_found = 1'b0; s_index = 4'd7;
        txn(3'd0, 1'b0);
        // RD of a valid entry then an invalid one
        csr_index = 4'd6; r_e = 1'b1; r_ps = 6'd12; r_vppn = 19'h7FFFF; r_asid = 10'h155;
        r_g = 1'b1; r_ppn0 = 20'hABCDE; r_ppn1 = 20'h12345; r_mat0 = 2'd1; r_mat1 = 2'd2;
        r_plv0 = 2'd3; r_plv1 = 2'd0; r_d0 = 1'b1; r_v0 = 1'b1; r_d1 = 1'b0; r_v1 = 1'b1;
        txn(3'd1, 1'b0);
        r_e = 1'b0;
        txn(3'd1, 1'b0);
        // WR with NE=1: refill ecode forces E, otherwise E follows ~NE
        csr_index = 4'd10; csr_ne = 1'b1; csr_ecode = 6'h3F;
        txn(3'd2, 1'b0);
        csr_index = 4'd10; csr_ne = 1'b1; csr_ecode = 6'h00;
        txn(3'd2, 1'b0);
        // illegal op
        txn(3'd6, 1'b0);

        // randomized operations
        for (int n = 0; n < 200; n++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            csr_index = IW'($urandom); csr_ne = 1'($urandom); csr_ps = 6'($urandom);
            csr_vppn = 19'($urandom); csr_asid = 10'($urandom);
            csr_ecode = ($urandom_range(0, 1) == 1) ? 6'h3F : 6'($urandom);
            csr_elo0 = 27'($urandom); csr_elo1 = 27'($urandom);
            inv_op = 5'($urandom); inv_asid = 10'($urandom); inv_vppn = 19'($urandom);
            s_found = 1'($urandom); s_index = IW'($urandom);
            r_e = 1'($urandom); r_ps = 6'($urandom); r_vppn = 19'($urandom);
            r_asid = 10'($urandom); r_g = 1'($urandom);
            r_ppn0 = 20'($urandom); r_ppn1 = 20'($urandom);
            r_plv0 = 2'($urandom); r_plv1 = 2'($urandom);
            r_mat0 = 2'($urandom); r_mat1 = 2'($urandom);
            r_d0 = 1'($urandom); r_v0 = 1'($urandom); r_d1 = 1'($urandom); r_v1 = 1'($urandom);
            txn(op, 1'b0);
        end

        // INV with reset asserted during EXEC
        inv_op = 5'd5; inv_asid = 10'h3C3; inv_vppn = 19'h0F0F0;
        txn(3'd4, 1'b1);
        @(negedge clk);
        chk("rst_recover_done", 64'(done), 64'd0);
        chk("rst_recover_ready", 64'(req_ready), 64'd1);
        // fill pointer restarts at 0 after reset
        txn(3'd3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
